// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline register with a 2-entry skid buffer.
// Carries PC, payload, branch-delay flag and exception code between two
// pipeline stages using valid/ready handshakes. in_ready is registered, so
// there is no combinational path from out_ready to in_ready.
// Priority per edge: reset > req (exception redirect) > flush > normal flow.
// Optional feature macro: PIPE_STAGE_STALL_CNT_EN enables the stall_cnt
// counter; when undefined, stall_cnt is tied to zero.
module pipe_stage_skid #(
  parameter int              PC_W       = 32,
  parameter int              PAYLOAD_W  = 32,
  parameter int              EXC_W      = 5,
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [PC_W-1:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_bd,
  input  logic [EXC_W-1:0]     in_exc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_bd,
  output logic [EXC_W-1:0]     out_exc,
  output logic [31:0]          stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t                 state_p1;
  state_t                 state_nx;
  logic                   rdy_p1;
  logic                   vld_p1;

  logic [PC_W-1:0]        main_pc_p1;
  logic [PAYLOAD_W-1:0]   main_payload_p1;
  logic                   main_bd_p1;
  logic [EXC_W-1:0]       main_exc_p1;

  logic [PC_W-1:0]        skid_pc_p1;
  logic [PAYLOAD_W-1:0]   skid_payload_p1;
  logic                   skid_bd_p1;
  logic [EXC_W-1:0]       skid_exc_p1;

  logic                   in_fire;
  logic                   out_fire;
  logic                   ld_main_in;
  logic                   ld_main_skid;
  logic                   ld_skid;

  assign in_ready = rdy_p1;
  assign in_fire  = in_valid & rdy_p1;
  assign out_fire = vld_p1 & out_ready;

  // State register; in_ready is precomputed from the next state so it is a flop
  always_ff @(posedge clk) begin
    if (reset || req) begin
      state_p1 <= EMPTY;
      rdy_p1   <= 1'b1;
    end else begin
      state_p1 <= state_nx;
      rdy_p1   <= (state_nx != TWO);
    end
  end

  // Next-state and storage-load decode; flush empties the stage and blocks loads
  always_comb begin
    state_nx     = state_p1;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_p1)
      EMPTY: begin
        if (in_fire) begin
          state_nx   = ONE;
          ld_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          ld_main_in = 1'b1;
        end else if (in_fire) begin
          state_nx = TWO;
          ld_skid  = 1'b1;
        end else if (out_fire) begin
          state_nx = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_nx     = ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
    if (flush) begin
      state_nx     = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  // Main and skid storage; reset/req redirect out_pc, flush leaves out_pc as is
  always_ff @(posedge clk) begin
    if (reset || req) begin
      main_pc_p1      <= reset ? RESET_PC : HANDLER_PC;
      main_payload_p1 <= '0;
      main_bd_p1      <= 1'b0;
      main_exc_p1     <= '0;
      skid_pc_p1      <= '0;
      skid_payload_p1 <= '0;
      skid_bd_p1      <= 1'b0;
      skid_exc_p1     <= '0;
    end else begin
      if (ld_main_in) begin
        main_pc_p1      <= in_pc;
        main_payload_p1 <= in_payload;
        main_bd_p1      <= in_bd;
        main_exc_p1     <= in_exc;
      end else if (ld_main_skid) begin
        main_pc_p1      <= skid_pc_p1;
        main_payload_p1 <= skid_payload_p1;
        main_bd_p1      <= skid_bd_p1;
        main_exc_p1     <= skid_exc_p1;
      end
      if (ld_skid) begin
        skid_pc_p1      <= in_pc;
        skid_payload_p1 <= in_payload;
        skid_bd_p1      <= in_bd;
        skid_exc_p1     <= in_exc;
      end
    end
  end

  // Output decode; an empty stage presents a nop with cleared flags
  always_comb begin
    vld_p1      = (state_p1 != EMPTY);
    out_valid   = vld_p1;
    out_pc      = main_pc_p1;
    out_payload = vld_p1 ? main_payload_p1 : '0;
    out_bd      = vld_p1 & main_bd_p1;
    out_exc     = vld_p1 ? main_exc_p1 : '0;
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0] stall_q;

  // Count edges where the head is held back by downstream; wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!req && !flush && vld_p1 && !out_ready) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, elastic successor to the fixed IF/ID pipeline register of the P7 MIPS CPU; usable between any two pipeline stages.
- Carries PC, a payload (instruction or decoded bundle), a branch-delay flag and an exception code.
- Replaces the single stall-enable register with valid/ready handshakes and a 2-entry skid buffer, giving full throughput without a combinational ready path.
- Keeps the existing priority: reset over exception-request redirect over flush.

Parameters:
PC_W, 32, PC field width
PAYLOAD_W, 32, payload width (instruction = 32)
EXC_W, 5, exception code width
RESET_PC, 32'h0000_3000, out_pc value after reset
HANDLER_PC, 32'h0000_4180, out_pc value after req

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
req  in  1  exception/interrupt taken; empties stage, redirects out_pc
flush  in  1  kill contents (branch/eret squash); out_pc holds
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept; registered
in_pc  in  PC_W  upstream PC
in_payload  in  PAYLOAD_W  upstream payload
in_bd  in  1  upstream branch-delay flag
in_exc  in  EXC_W  upstream exception code
out_valid  out  1  downstream entry valid
out_ready  in  1  downstream accepts
out_pc  out  PC_W  head PC
out_payload  out  PAYLOAD_W  head payload
out_bd  out  1  head branch-delay flag
out_exc  out  EXC_W  head exception code
stall_cnt  out  32  stall-cycle counter (optional feature)

Behaviour:
- Single clock domain. Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Storage: main register (drives out_*) and skid register.
- State: EMPTY (0 entries), ONE (main valid), TWO (main and skid valid).
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Outputs:
  - out_valid = state != EMPTY.
  - in_ready registered: 1 in EMPTY and ONE, 0 in TWO.
- Transitions, no reset/req/flush:
  - EMPTY: in_fire -> ONE, main <= in. Latency is 1 cycle, in to out.
  - ONE: in_fire & out_fire -> ONE, main <= in. in_fire & !out_fire -> TWO, skid <= in. !in_fire & out_fire -> EMPTY. Neither -> hold.
  - TWO: out_fire -> ONE, main <= skid. No input is accepted.
- Ordering: strictly FIFO; sustained throughput is 1 entry/cycle when out_ready is held high.
- Fields with out_valid=0:
  - out_payload = 0 (nop), out_bd = 0, out_exc = 0.
  - out_pc = last value, except after reset or req.
- Priority: reset > req > flush > normal, evaluated per edge.
  - reset: state EMPTY; out_pc=RESET_PC; out_payload=0; out_bd=0; out_exc=0; skid cleared; in_ready=1; stall_cnt=0.
  - req: as reset, but out_pc=HANDLER_PC and stall_cnt is unaffected. in_valid on the same edge is discarded.
  - flush: state EMPTY; payload/bd/exc cleared; out_pc holds; in_ready=1. Same-edge input is discarded; same-edge out_fire is still considered consumed downstream.
- Reset or req mid-transfer (TWO state) drops both entries. No partial state remains.
- Input fields are don't-care when in_valid=0. The block never drives X after reset.
- Widths are fixed by parameters. No arithmetic is performed except stall_cnt, which wraps modulo 2^32.

Optional Feature:
- Macro: PIPE_STAGE_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 on each edge where out_valid & !out_ready and neither reset nor req is asserted. It wraps from 32'hFFFF_FFFF to 0, clears on reset, and holds on req/flush.
- Undefined: stall_cnt is tied to 32'h0 and the counter logic is absent.

Test Plan:
1. Reset, then in_valid=1, pc=3000, payload=24010001, out_ready=1 for one cycle -> next cycle out_valid=1, out_pc=3000, out_payload=24010001; after reset out_pc=3000, payload 0.
2. Stream pcs 3000, 3004, 3008, 300C with out_ready=1 every cycle -> outputs appear 1 cycle later in order, no bubbles, in_ready stays 1.
3. out_ready=0, send 3000 and 3004 -> state TWO, in_ready=0 the following cycle, 3008 is held upstream. Raise out_ready -> 3000, 3004, 3008 delivered in order, nothing lost or duplicated.
4. In state TWO, assert req together with in_valid -> next cycle out_valid=0, out_pc=4180, payload=0, bd=0, exc=0, in_ready=1; discarded entries never appear.
5. Flush with pc=3010 at head and same-edge in_valid -> out_valid=0, out_pc=3010, payload=0; next accepted entry is the one after flush only.
6. With PIPE_STAGE_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 7 cycles -> stall_cnt=7. Assert reset -> 0. Preload near wrap (force) -> rolls FFFFFFFF to 0. Without macro -> stall_cnt stays 0.
